// File: rtl/adc_capture_buf_if.sv
`default_nettype none
// ============================================================================
//  Module   : adc_capture_buf_if
//  Purpose  : Capture-control and readback bus of the ADC capture buffer.
//             The master side arms captures, feeds samples and reads back.
//             The slave side is the capture buffer itself.
//  Revision : 1.0  initial release
// ============================================================================
interface adc_capture_buf_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
);
  logic                  arm;
  logic                  adc_valid;
  logic [DATA_WIDTH-1:0] adc_data;
  logic [DATA_WIDTH-1:0] trig_level;
  logic                  force_trig;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output arm, adc_valid, adc_data, trig_level, force_trig, rd_en, rd_addr,
    input  busy, done, rd_data, rd_valid
  );

  modport slave (
    input  arm, adc_valid, adc_data, trig_level, force_trig, rd_en, rd_addr,
    output busy, done, rd_data, rd_valid
  );
endinterface
`default_nettype wire

// File: rtl/adc_capture_buf.sv
`default_nettype none
// ============================================================================
//  Module   : adc_capture_buf
//  Purpose  : Circular 2**ADDR_WIDTH x DATA_WIDTH sample buffer with
//             pre-/post-trigger capture. A rising crossing of trig_level (or
//             a manual force) freezes a record of PRE_TRIG samples before the
//             trigger, the trigger sample and the samples after it. The frozen
//             record is read back through a trigger-relative address with a
//             1-cycle registered read.
//  Revision : 1.0  initial release
// ============================================================================
module adc_capture_buf #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int PRE_TRIG   = 256
) (
  input wire clk,
  input wire reset,
  adc_capture_buf_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Address-width copies of the capture geometry.
  localparam logic [ADDR_WIDTH-1:0] PRE_TRIG_A = ADDR_WIDTH'(PRE_TRIG);
  localparam logic [ADDR_WIDTH-1:0] PRE_LAST   = ADDR_WIDTH'(PRE_TRIG - 1);
  localparam logic [ADDR_WIDTH-1:0] POST_LOAD  = ADDR_WIDTH'(DEPTH - PRE_TRIG - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A      = ADDR_WIDTH'(1);

  // A zero pre-trigger length skips PREFILL; a full-depth pre-trigger
  // length leaves nothing to collect after the trigger.
  localparam logic HAS_PREFILL = (PRE_TRIG != 0);
  localparam logic HAS_POST    = (PRE_TRIG != DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PREFILL   = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wp;
  logic [ADDR_WIDTH-1:0] pre_cnt;
  logic [ADDR_WIDTH-1:0] post_cnt;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [DATA_WIDTH-1:0] prev_sample;
  logic                  prev_ok;
  logic                  force_pend;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  logic                  start;
  logic                  wr_en;
  logic                  track;
  logic                  crossing;
  logic                  trig_hit;
  logic [ADDR_WIDTH-1:0] rd_phys;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and per-cycle capture strobes.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    wr_en    = 1'b0;
    track    = 1'b0;
    trig_hit = 1'b0;
    // A crossing needs a previous sample from this capture, so the first
    // sample after arm can never be a level trigger.
    crossing = prev_ok && (prev_sample < bus.trig_level) &&
               (bus.adc_data >= bus.trig_level);
    case (state)
      IDLE, DONE: begin
        if (bus.arm) begin
          start    = 1'b1;
          state_nx = HAS_PREFILL ? PREFILL : WAIT_TRIG;
        end
      end
      PREFILL: begin
        if (bus.adc_valid) begin
          wr_en = 1'b1;
          track = 1'b1;
          if (pre_cnt == PRE_LAST) begin
            state_nx = WAIT_TRIG;
          end
        end
      end
      WAIT_TRIG: begin
        if (bus.adc_valid) begin
          wr_en = 1'b1;
          track = 1'b1;
          if (crossing || bus.force_trig || force_pend) begin
            trig_hit = 1'b1;
            state_nx = HAS_POST ? POST : DONE;
          end
        end
      end
      POST: begin
        if (bus.adc_valid) begin
          wr_en = 1'b1;
          if (post_cnt == ONE_A) begin
            state_nx = DONE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Write pointer, counters, trigger history and record origin.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp          <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      start_addr  <= '0;
      prev_sample <= '0;
      prev_ok     <= 1'b0;
      force_pend  <= 1'b0;
    end else begin
      if (start) begin
        wp         <= '0;
        pre_cnt    <= '0;
        post_cnt   <= '0;
        prev_ok    <= 1'b0;
        force_pend <= 1'b0;
      end
      if (wr_en) begin
        wp <= wp + ONE_A;
      end
      if (wr_en && (state == PREFILL)) begin
        pre_cnt <= pre_cnt + ONE_A;
      end
      if (track) begin
        prev_sample <= bus.adc_data;
        prev_ok     <= 1'b1;
      end
      // A force seen without a sample is remembered until the next sample.
      if ((state == WAIT_TRIG) && bus.force_trig && !bus.adc_valid) begin
        force_pend <= 1'b1;
      end
      if (trig_hit) begin
        start_addr <= wp - PRE_TRIG_A;
        post_cnt   <= POST_LOAD;
        force_pend <= 1'b0;
      end
      if (wr_en && (state == POST)) begin
        post_cnt <= post_cnt - ONE_A;
      end
    end
  end

  // Sample RAM write port; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wp] <= bus.adc_data;
    end
  end

  assign rd_phys = start_addr + bus.rd_addr;

  // Registered read of the frozen record; rd_data holds outside DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if ((state == DONE) && bus.rd_en) begin
      rd_data_q  <= mem[rd_phys];
      rd_valid_q <= 1'b1;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign bus.busy     = (state == PREFILL) || (state == WAIT_TRIG) || (state == POST);
  assign bus.done     = (state == DONE);
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_capture_buf
//  Purpose  : Directed bench for adc_capture_buf. Three instances cover
//             PRE_TRIG = 256, 0 and 2047; sample stimulus is shared, arm and
//             rd_en are per instance. Read expectations are queued at issue
//             time and checked by a monitor when rd_valid appears.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adc_capture_buf;
  localparam int AW = 11;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          adc_valid, force_trig;
  logic [DW-1:0] adc_data, trig_level;
  logic [AW-1:0] rd_addr;
  logic          arm_m, arm_z, arm_f;
  logic          rd_en_m, rd_en_z, rd_en_f;

  adc_capture_buf_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_m ();
  adc_capture_buf_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_z ();
  adc_capture_buf_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_f ();

  assign bus_m.arm = arm_m;        assign bus_z.arm = arm_z;        assign bus_f.arm = arm_f;
  assign bus_m.rd_en = rd_en_m;    assign bus_z.rd_en = rd_en_z;    assign bus_f.rd_en = rd_en_f;
  assign bus_m.adc_valid = adc_valid;   assign bus_z.adc_valid = adc_valid;   assign bus_f.adc_valid = adc_valid;
  assign bus_m.adc_data = adc_data;     assign bus_z.adc_data = adc_data;     assign bus_f.adc_data = adc_data;
  assign bus_m.trig_level = trig_level; assign bus_z.trig_level = trig_level; assign bus_f.trig_level = trig_level;
  assign bus_m.force_trig = force_trig; assign bus_z.force_trig = force_trig; assign bus_f.force_trig = force_trig;
  assign bus_m.rd_addr = rd_addr;       assign bus_z.rd_addr = rd_addr;       assign bus_f.rd_addr = rd_addr;

  adc_capture_buf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PRE_TRIG(256))
    dut_m (.clk(clk), .reset(reset), .bus(bus_m));
  adc_capture_buf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PRE_TRIG(0))
    dut_z (.clk(clk), .reset(reset), .bus(bus_z));
  adc_capture_buf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PRE_TRIG(2047))
    dut_f (.clk(clk), .reset(reset), .bus(bus_f));

  int n_pass = 0;
  int n_total = 0;

  logic [DW-1:0] q_m[$];
  logic [DW-1:0] q_z[$];
  logic [DW-1:0] q_f[$];

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Scoreboard monitor: every rd_valid must match the oldest queued read.
  always @(negedge clk) begin
    if (bus_m.rd_valid) begin
      if (q_m.size() == 0) check("unexpected rd_valid (PRE_TRIG=256)", 1, 0);
      else check("rd_data (PRE_TRIG=256)", int'(bus_m.rd_data), int'(q_m.pop_front()));
    end
    if (bus_z.rd_valid) begin
      if (q_z.size() == 0) check("unexpected rd_valid (PRE_TRIG=0)", 1, 0);
      else check("rd_data (PRE_TRIG=0)", int'(bus_z.rd_data), int'(q_z.pop_front()));
    end
    if (bus_f.rd_valid) begin
      if (q_f.size() == 0) check("unexpected rd_valid (PRE_TRIG=2047)", 1, 0);
      else check("rd_data (PRE_TRIG=2047)", int'(bus_f.rd_data), int'(q_f.pop_front()));
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic [DW-1:0] d);
    adc_valid = 1'b1;
    adc_data  = d;
    tick();
    adc_valid = 1'b0;
  endtask

  // Issue one read on instance which (0=256, 1=0, 2=2047) and queue its expectation.
  task automatic rd(input int which, input int a, input logic [DW-1:0] e);
    rd_addr = AW'(a);
    case (which)
      0: begin rd_en_m = 1'b1; q_m.push_back(e); end
      1: begin rd_en_z = 1'b1; q_z.push_back(e); end
      default: begin rd_en_f = 1'b1; q_f.push_back(e); end
    endcase
    tick();
    rd_en_m = 1'b0;
    rd_en_z = 1'b0;
    rd_en_f = 1'b0;
  endtask

  task automatic arm_pulse(input int which);
    case (which)
      0: arm_m = 1'b1;
      1: arm_z = 1'b1;
      default: arm_f = 1'b1;
    endcase
    tick();
    arm_m = 1'b0;
    arm_z = 1'b0;
    arm_f = 1'b0;
  endtask

  function automatic logic [DW-1:0] gate_smp(input int n);
    if (n == 50 || n == 399) return 8'h7F;
    if (n == 51 || n == 400) return 8'h80;
    if (n > 400) return 8'h11;
    return 8'h00;
  endfunction

  initial begin
    reset = 1'b1; adc_valid = 1'b0; force_trig = 1'b0; adc_data = '0;
    trig_level = 8'h80; rd_addr = '0;
    arm_m = 1'b0; arm_z = 1'b0; arm_f = 1'b0;
    rd_en_m = 1'b0; rd_en_z = 1'b0; rd_en_f = 1'b0;

    // Reset with adc_valid toggling, then idle without arm.
    adc_valid = 1'b1; tick(); adc_valid = 1'b0; tick();
    check("reset busy", int'(bus_m.busy), 0);
    check("reset done", int'(bus_m.done), 0);
    check("reset rd_valid", int'(bus_m.rd_valid), 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin adc_valid = i[0]; adc_data = 8'(i); tick(); end
    adc_valid = 1'b0;
    check("idle busy without arm", int'(bus_m.busy), 0);
    check("idle done without arm", int'(bus_m.done), 0);
    rd_en_m = 1'b1; tick(); rd_en_m = 1'b0;
    check("rd_valid after rd_en in IDLE", int'(bus_m.rd_valid), 0);

    // Basic ramp capture: trigger on 0x80 at sample 384.
    arm_pulse(0);
    check("basic busy after arm", int'(bus_m.busy), 1);
    for (int n = 0; n < 2175; n++) begin
      if (n == 1000) arm_m = 1'b1;   // arm during POST must be ignored
      smp(8'(n % 256));
      arm_m = 1'b0;
    end
    check("basic done before last post sample", int'(bus_m.done), 0);
    smp(8'(2175 % 256));
    check("basic done after 1791 post samples", int'(bus_m.done), 1);
    check("basic busy in DONE", int'(bus_m.busy), 0);
    rd(0, 256, 8'h80);
    rd(0, 0, 8'h80);
    rd(0, 2047, 8'h7F);
    for (int k = 250; k < 262; k++) rd(0, k, 8'((128 + k) % 256));
    tick();
    check("rd_valid after rd_en drops", int'(bus_m.rd_valid), 0);

    // Trigger gating: crossing at 51 falls in PREFILL, crossing at 400 fires.
    arm_pulse(0);
    check("re-arm busy next cycle", int'(bus_m.busy), 1);
    check("re-arm done cleared", int'(bus_m.done), 0);
    for (int n = 0; n < 2191; n++) smp(gate_smp(n));
    check("gate done before last post sample", int'(bus_m.done), 0);
    smp(gate_smp(2191));
    check("gate done", int'(bus_m.done), 1);
    rd(0, 256, 8'h80);
    rd(0, 255, 8'h7F);
    rd(0, 257, 8'h11);
    rd(0, 0, 8'h00);
    rd(0, 2047, 8'h11);
    tick();

    // force_trig without adc_valid fires on the next sample.
    arm_pulse(0);
    for (int n = 0; n < 300; n++) smp(8'h10);
    force_trig = 1'b1; adc_valid = 1'b0; tick(); force_trig = 1'b0;
    tick(); tick(); tick();
    check("force pending still busy", int'(bus_m.busy), 1);
    for (int n = 0; n < 1791; n++) smp(8'h10);
    check("force done before last post sample", int'(bus_m.done), 0);
    smp(8'h10);
    check("force done", int'(bus_m.done), 1);
    for (int k = 0; k < 2048; k++) rd(0, k, 8'h10);
    tick();

    // Wrap: force trigger at wp=100 (sample 2148), origin at address 1892.
    arm_pulse(0);
    for (int n = 0; n < 2148; n++) smp(8'(n % 127));
    force_trig = 1'b1; smp(8'(2148 % 127)); force_trig = 1'b0;
    for (int n = 2149; n < 3939; n++) smp(8'(n % 127));
    check("wrap done before last post sample", int'(bus_m.done), 0);
    smp(8'(3939 % 127));
    check("wrap done", int'(bus_m.done), 1);
    rd(0, 0, 8'(1892 % 127));
    rd(0, 256, 8'(2148 % 127));
    rd(0, 2047, 8'(3939 % 127));
    for (int k = 150; k < 162; k++) rd(0, k, 8'((1892 + k) % 127));
    tick();

    // Reset during POST: done must never assert.
    arm_pulse(0);
    for (int n = 0; n < 300; n++) smp(8'h20);
    force_trig = 1'b1; smp(8'h20); force_trig = 1'b0;
    for (int n = 0; n < 100; n++) smp(8'h20);
    reset = 1'b1; smp(8'h20); reset = 1'b0;
    check("reset in POST busy", int'(bus_m.busy), 0);
    check("reset in POST done", int'(bus_m.done), 0);
    for (int n = 0; n < 2000; n++) smp(8'h20);
    check("no done after reset in POST", int'(bus_m.done), 0);
    rd_en_m = 1'b1; tick(); rd_en_m = 1'b0; tick();
    check("rd_valid in IDLE after reset", int'(bus_m.rd_valid), 0);

    // PRE_TRIG=0: first sample 0x90 must not trigger; 0x20 -> 0x85 fires.
    arm_pulse(1);
    check("pre0 busy after arm", int'(bus_z.busy), 1);
    smp(8'h90); smp(8'h20); smp(8'h85);
    for (int n = 3; n < 2049; n++) smp(8'(n % 64));
    check("pre0 done before last post sample", int'(bus_z.done), 0);
    smp(8'(2049 % 64));
    check("pre0 done", int'(bus_z.done), 1);
    rd(1, 0, 8'h85);
    rd(1, 1, 8'd3);
    rd(1, 2047, 8'd1);
    tick();

    // PRE_TRIG=2047: done on the trigger sample itself.
    arm_pulse(2);
    for (int n = 0; n < 2047; n++) smp(8'(n % 100));
    smp(8'h05);
    check("pre2047 busy before trigger", int'(bus_f.busy), 1);
    check("pre2047 done before trigger", int'(bus_f.done), 0);
    smp(8'h90);
    check("pre2047 done on trigger", int'(bus_f.done), 1);
    check("pre2047 busy on trigger", int'(bus_f.busy), 0);
    rd(2, 2047, 8'h90);
    rd(2, 2046, 8'h05);
    rd(2, 0, 8'd1);
    rd(2, 1, 8'd2);

    tick(); tick(); tick();
    check("reads outstanding (PRE_TRIG=256)", q_m.size(), 0);
    check("reads outstanding (PRE_TRIG=0)", q_z.size(), 0);
    check("reads outstanding (PRE_TRIG=2047)", q_f.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
